demux4_capture: RTL and testbench

Registered 1-to-4 demultiplexing capture block: the write-side counterpart of the 4:1 mux cell. Each enabled clock edge steers data input D into one of four held output slots Z0..Z3, selected either explicitly by S1:S0 (the same encoding the mux uses to pick I0..I3) or by an internal auto-incrementing pointer. It tracks which slots have been filled and flags frame completion, so a downstream mux4 can read back a coherent 4-slot frame.

---
 rtl/demux4_pkg.sv | 18 +
 rtl/demux4_capture_ctrl.sv | 71 +++++++
 rtl/demux4_capture.sv | 84 ++++++++
 tb/tb_demux4_capture.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/demux4_pkg.sv
// Shared types and helpers for the demux4 capture block.
package demux4_pkg;

  typedef logic [1:0] slot_idx_t;

  localparam slot_idx_t SLOT0 = 2'd0;
  localparam slot_idx_t SLOT1 = 2'd1;
  localparam slot_idx_t SLOT2 = 2'd2;
  localparam slot_idx_t SLOT3 = 2'd3;

  localparam logic [3:0] MASK_ALL = 4'b1111;

  // Slot index to one-hot slot mask (bit i <-> Zi).
  function automatic logic [3:0] onehot4(input slot_idx_t idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/demux4_capture_ctrl.sv
// Frame bookkeeping: auto pointer, written-slot mask, FULL level and FRAME pulse.
// Produces the per-slot write enables for the slot registers in the top level.
module demux4_capture_ctrl
  import demux4_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      en_i,
  input  logic      auto_i,
  input  logic      clr_i,
  input  slot_idx_t idx_i,
  input  logic      idx_valid_i,
  output slot_idx_t ptr_o,
  output logic      full_o,
  output logic      frame_o,
  output logic [3:0] we_o
);

  slot_idx_t  ptr_q, ptr_d;
  logic [3:0] mask_q, mask_d;
  logic       full_q, full_d;
  logic       frame_q, frame_d;
  logic [3:0] mask_new;
  logic       write;

  // A write happens only when not cleared and the slot index is well defined.
  assign write = en_i & ~clr_i & idx_valid_i;
  assign we_o  = write ? onehot4(idx_i) : 4'b0000;

  // Next-state: CLR has priority, then a write, otherwise hold with FRAME dropped.
  always_comb begin
    ptr_d    = ptr_q;
    mask_d   = mask_q;
    full_d   = full_q;
    frame_d  = 1'b0;
    // A write into a full frame starts a fresh frame with just this slot.
    mask_new = full_q ? onehot4(idx_i) : (mask_q | onehot4(idx_i));
    if (clr_i) begin
      ptr_d  = SLOT0;
      mask_d = 4'b0000;
      full_d = 1'b0;
    end else if (write) begin
      mask_d  = mask_new;
      full_d  = (mask_new == MASK_ALL);
      frame_d = (mask_new == MASK_ALL) && (mask_q != MASK_ALL);
      if (auto_i) begin
        ptr_d = ptr_q + 2'd1;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q   <= SLOT0;
      mask_q  <= 4'b0000;
      full_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
      full_q  <= full_d;
      frame_q <= frame_d;
    end
  end

  assign ptr_o   = ptr_q;
  assign full_o  = full_q;
  assign frame_o = frame_q;

endmodule

// File: rtl/demux4_capture.sv
// Registered 1-to-4 demux capture: steers D into one of four held slots,
// selected by {S1,S0} or by an internal auto-incrementing pointer.
module demux4_capture
  import demux4_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
`ifdef USE_POWER_PINS
  inout  wire              VDD,
  inout  wire              VSS,
`endif
  input  logic             CLK,
  input  logic             RN,
  input  logic [WIDTH-1:0] D,
  input  logic             S0,
  input  logic             S1,
  input  logic             EN,
  input  logic             AUTO,
  input  logic             CLR,
  output logic [WIDTH-1:0] Z0,
  output logic [WIDTH-1:0] Z1,
  output logic [WIDTH-1:0] Z2,
  output logic [WIDTH-1:0] Z3,
  output logic [1:0]       PTR,
  output logic             FULL,
  output logic             FRAME
);

  slot_idx_t              ptr;
  slot_idx_t              idx;
  logic                   idx_valid;
  logic [3:0]             we;
  logic [3:0][WIDTH-1:0]  z_q;

  assign idx = AUTO ? ptr : {S1, S0};

  // An unknown explicit select must not write any slot or touch the mask.
`ifdef SYNTHESIS
  assign idx_valid = 1'b1;
`else
  assign idx_valid = AUTO | ~$isunknown({S1, S0});
`endif

  demux4_capture_ctrl u_ctrl (
    .clk_i       (CLK),
    .rst_ni      (RN),
    .en_i        (EN),
    .auto_i      (AUTO),
    .clr_i       (CLR),
    .idx_i       (idx),
    .idx_valid_i (idx_valid),
    .ptr_o       (ptr),
    .full_o      (FULL),
    .frame_o     (FRAME),
    .we_o        (we)
  );

  // Slot registers: each loads D when its write enable is set.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      z_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          z_q[i] <= D;
        end
      end
    end
  end

  assign Z0  = z_q[0];
  assign Z1  = z_q[1];
  assign Z2  = z_q[2];
  assign Z3  = z_q[3];
  assign PTR = ptr;

`ifndef SYNTHESIS
  // Flag misuse: explicit select must be known whenever a write is requested.
  a_sel_known: assert property (@(posedge CLK) disable iff (!RN)
      (EN && !AUTO && !CLR) |-> !$isunknown({S1, S0}))
    else $error("demux4_capture: unknown S1/S0 on explicit write");
`endif

endmodule

// File: tb/tb_demux4_capture.sv
// Scoreboard bench for demux4_capture: driver pushes reference-model
// expectations, a monitor pops and compares after every capturing edge.
module tb_demux4_capture;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [3:0][W-1:0] z;
    logic [1:0]        ptr;
    logic              full;
    logic              frame;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RN  = 1'b0;
  logic [W-1:0] D   = '0;
  logic         S0  = 1'b0;
  logic         S1  = 1'b0;
  logic         EN  = 1'b0;
  logic         AUTO = 1'b0;
  logic         CLR = 1'b0;
  logic [W-1:0] Z0, Z1, Z2, Z3;
  logic [1:0]   PTR;
  logic         FULL, FRAME;

  int errors = 0;
  int checks = 0;

  exp_t exp_q[$];

  // Reference model state: slot contents, which slots were written this frame.
  logic [W-1:0] m_z[4];
  bit           m_written[4];
  int           m_ptr;
  bit           m_full;
  bit           m_frame;

  demux4_capture #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RN    (RN),
    .D     (D),
    .S0    (S0),
    .S1    (S1),
    .EN    (EN),
    .AUTO  (AUTO),
    .CLR   (CLR),
    .Z0    (Z0),
    .Z1    (Z1),
    .Z2    (Z2),
    .Z3    (Z3),
    .PTR   (PTR),
    .FULL  (FULL),
    .FRAME (FRAME)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int written_count();
    int n = 0;
    for (int i = 0; i < 4; i++) n += m_written[i] ? 1 : 0;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_z[i] = '0;
      m_written[i] = 1'b0;
    end
    m_ptr = 0;
    m_full = 1'b0;
    m_frame = 1'b0;
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    for (int i = 0; i < 4; i++) e.z[i] = m_z[i];
    e.ptr   = 2'(m_ptr);
    e.full  = m_full;
    e.frame = m_frame;
    return e;
  endfunction

  // One clock edge of stimulus; the model's post-edge state is queued.
  task automatic drive(input bit en, input bit au, input bit clr, input int s,
                       input logic [W-1:0] d);
    int  idx;
    bit  was_complete;
    @(negedge CLK);
    EN = en; AUTO = au; CLR = clr; D = d;
    S1 = s[1]; S0 = s[0];
    if (clr) begin
      for (int i = 0; i < 4; i++) m_written[i] = 1'b0;
      m_ptr = 0; m_full = 1'b0; m_frame = 1'b0;
    end else if (en) begin
      idx = au ? m_ptr : s;
      m_z[idx] = d;
      if (m_full) begin
        for (int i = 0; i < 4; i++) m_written[i] = 1'b0;
        m_full = 1'b0;
      end
      was_complete = (written_count() == 4);
      m_written[idx] = 1'b1;
      m_frame = !was_complete && (written_count() == 4);
      m_full  = (written_count() == 4);
      if (au) m_ptr = (m_ptr + 1) % 4;
    end else begin
      m_frame = 1'b0;
    end
    exp_q.push_back(snapshot());
  endtask

  // Monitor: after each rising edge, compare DUT outputs against the oldest expectation.
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("Z0", Z0, e.z[0]);
      check("Z1", Z1, e.z[1]);
      check("Z2", Z2, e.z[2]);
      check("Z3", Z3, e.z[3]);
      check("PTR", W'(PTR), W'(e.ptr));
      check("FULL", W'(FULL), W'(e.full));
      check("FRAME", W'(FRAME), W'(e.frame));
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge CLK);
    check("reset_full", W'(FULL), '0);
    check("reset_ptr", W'(PTR), '0);
    RN = 1'b1;

    // Auto fill with 1,0,1,1.
    drive(1, 1, 0, 0, 8'h01);
    drive(1, 1, 0, 0, 8'h00);
    drive(1, 1, 0, 0, 8'h01);
    drive(1, 1, 0, 0, 8'h01);
    drive(0, 1, 0, 0, 8'h00);

    // Explicit select incl. a duplicate write to slot 0.
    drive(0, 0, 1, 0, 8'h00);
    drive(1, 0, 0, 3, 8'hA3);
    drive(1, 0, 0, 0, 8'hA0);
    drive(1, 0, 0, 0, 8'hB0);
    drive(1, 0, 0, 2, 8'hA2);
    drive(1, 0, 0, 1, 8'hA1);

    // Frame rollover: write slot 2 while FULL.
    drive(1, 0, 0, 2, 8'hC2);
    drive(0, 0, 0, 0, 8'h00);

    // CLR priority with three slots written.
    drive(0, 0, 1, 0, 8'h00);
    drive(1, 0, 0, 0, 8'h10);
    drive(1, 0, 0, 1, 8'h11);
    drive(1, 0, 0, 2, 8'h12);
    drive(1, 0, 1, 3, 8'hEE);
    drive(0, 0, 0, 0, 8'h00);

    // Nine auto writes 0x00..0x08 across a wrap.
    for (int i = 0; i < 9; i++) drive(1, 1, 0, 0, W'(i));
    drive(0, 0, 0, 0, 8'h00);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 15) == 0, int'($urandom_range(0, 3)),
            W'($urandom_range(1, 255)));
    end

    // Partial frame then asynchronous reset, checked before any edge.
    drive(1, 1, 0, 0, 8'h5A);
    drive(1, 0, 0, 3, 8'hA5);
    drive(0, 0, 0, 0, 8'h00);
    repeat (2) @(posedge CLK);
    check("queue_drained", W'(exp_q.size()), '0);
    @(negedge CLK);
    #2;
    RN = 1'b0;
    #1;
    check("arst_Z0", Z0, '0);
    check("arst_Z1", Z1, '0);
    check("arst_Z2", Z2, '0);
    check("arst_Z3", Z3, '0);
    check("arst_PTR", W'(PTR), '0);
    check("arst_FULL", W'(FULL), '0);
    check("arst_FRAME", W'(FRAME), '0);
    model_reset();
    @(negedge CLK);
    RN = 1'b1;

    // After reset no stale frame completes; fill again from slot 0.
    drive(0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, W'(8'h40 + i));
    drive(1, 1, 0, 0, 8'h77);
    drive(0, 0, 0, 0, 8'h00);

    repeat (3) @(posedge CLK);
    #2;
    check("final_drain", W'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
